// File: rtl/bcd_seven_seg_scan.sv
// Four-digit common-anode 7-segment scanner fed by a BCD converter.
// Captured digits wait in a pending register and swap into view only at a frame boundary.
module bcd_seven_seg_scan #(
    parameter int REFRESH_DIV   = 5000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [3:0]  ones,
    input  logic [3:0]  tens,
    input  logic [3:0]  hundreds,
    input  logic [3:0]  thousands,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);

    localparam int             PW     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]  PS_MAX = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] prescaler_r;
    logic [1:0]    idx_r;
    logic [15:0]   pending_r;
    logic [15:0]   shown_r;
    logic [3:0]    an_r;
    logic [6:0]    seg_r;
    logic          frame_done_r;

    logic          tick_s;
    logic          boundary_s;
    logic [3:0]    digit_s;
    logic          blank_s;
    logic [3:0]    an_next_s;
    logic [6:0]    seg_next_s;
    logic [15:0]   digits_in_s;

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal codes show a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Scan timing, digit selection and leading-zero blanking for the next drive value.
    always_comb begin
        digits_in_s = {thousands, hundreds, tens, ones};
        tick_s      = (prescaler_r == PS_MAX);
        boundary_s  = tick_s && (idx_r == 2'd3);
        an_next_s   = ~(4'b0001 << idx_r);
        case (idx_r)
            2'd0:    digit_s = shown_r[3:0];
            2'd1:    digit_s = shown_r[7:4];
            2'd2:    digit_s = shown_r[11:8];
            2'd3:    digit_s = shown_r[15:12];
            default: digit_s = 4'd0;
        endcase
        // Any code 1..15 above a position counts as significant, so dashes stop blanking.
        case (idx_r)
            2'd3:    blank_s = (shown_r[15:12] == 4'd0);
            2'd2:    blank_s = (shown_r[15:8] == 8'd0);
            2'd1:    blank_s = (shown_r[15:4] == 12'd0);
            default: blank_s = 1'b0;
        endcase
        if (BLANK_LEADING && blank_s) begin
            seg_next_s = 7'b1111111;
        end else begin
            seg_next_s = decode(digit_s);
        end
    end

    // Prescaler, digit index, capture registers and registered display outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler_r  <= '0;
            idx_r        <= 2'd0;
            pending_r    <= 16'd0;
            shown_r      <= 16'd0;
            an_r         <= 4'b1111;
            seg_r        <= 7'b1111111;
            frame_done_r <= 1'b0;
        end else begin
            prescaler_r <= tick_s ? '0 : prescaler_r + PW'(1);
            if (tick_s) begin
                idx_r <= idx_r + 2'd1;
            end
            if (load) begin
                pending_r <= digits_in_s;
            end
            // A strobe on the boundary cycle itself bypasses pending into the next frame.
            if (boundary_s) begin
                shown_r <= load ? digits_in_s : pending_r;
            end
            an_r         <= an_next_s;
            seg_r        <= seg_next_s;
            frame_done_r <= boundary_s;
        end
    end

    assign an         = an_r;
    assign seg        = seg_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_bcd_seven_seg_scan.sv
// Directed, table-driven bench for bcd_seven_seg_scan with REFRESH_DIV=4,
// running a blanking instance and a non-blanking instance side by side.
module tb_bcd_seven_seg_scan;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [3:0] ones, tens, hundreds, thousands;
    logic [3:0] an, an_nb;
    logic [6:0] seg, seg_nb;
    logic       frame_done, frame_done_nb;

    int checks;
    int failures;

    typedef struct {
        logic [15:0]     digits;   // {thousands,hundreds,tens,ones}
        logic [3:0][6:0] exp_bl;   // index k = digit k, blanking instance
        logic [3:0][6:0] exp_nb;   // index k = digit k, non-blanking instance
    } vec_t;

    vec_t vecs[5];

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] Z  = 7'b1000000;

    bcd_seven_seg_scan #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .load(load),
        .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
        .an(an), .seg(seg), .frame_done(frame_done)
    );

    bcd_seven_seg_scan #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .load(load),
        .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
        .an(an_nb), .seg(seg_nb), .frame_done(frame_done_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out(input string name, input logic [3:0] ea, input logic [6:0] es,
                             input logic [6:0] es_nb, input logic ef);
        checks++;
        if (an !== ea || seg !== es || frame_done !== ef ||
            an_nb !== ea || seg_nb !== es_nb || frame_done_nb !== ef) begin
            failures++;
            $display("FAIL %s: got an=%b seg=%b fd=%b an_nb=%b seg_nb=%b fd_nb=%b, expected an=%b seg=%b seg_nb=%b fd=%b",
                     name, an, seg, frame_done, an_nb, seg_nb, frame_done_nb, ea, es, es_nb, ef);
        end
    endtask

    // Sample at negedges until frame_done is seen; a lost frame_done is a failure.
    task automatic wait_fd();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 100);
        checks++;
        if (frame_done !== 1'b1) begin
            failures++;
            $display("FAIL wait_fd: got no frame_done within 100 cycles, expected a pulse");
        end
    endtask

    // Called at a frame_done negedge; checks every cycle of the following frame.
    // Any load set up by the caller lasts exactly one clock edge.
    // bmode: load 1,0,0,0 on the boundary cycle and 0,0,0,6 on the cycle after it.
    task automatic run_frame(input string name, input logic [3:0][6:0] e_bl,
                             input logic [3:0][6:0] e_nb, input bit bmode);
        int k;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            load = 1'b0;
            k = (c - 1) / 4;
            check_out($sformatf("%s c=%0d", name, c), ~(4'b0001 << k), e_bl[k], e_nb[k], c == 16);
            if (bmode && c == 15) begin
                {thousands, hundreds, tens, ones} = 16'h1000;
                load = 1'b1;
            end
            if (bmode && c == 16) begin
                {thousands, hundreds, tens, ones} = 16'h0006;
                load = 1'b1;
            end
        end
    endtask

    initial begin
        logic [3:0][6:0] prev_bl, prev_nb, zero_bl, zero_nb;
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        load  = 1'b0;
        {thousands, hundreds, tens, ones} = 16'h0000;

        zero_bl = {BL, BL, BL, Z};
        zero_nb = {Z, Z, Z, Z};
        vecs[0] = '{16'h2375, {7'b0100100, 7'b0110000, 7'b1111000, 7'b0010010},
                              {7'b0100100, 7'b0110000, 7'b1111000, 7'b0010010}};
        vecs[1] = '{16'h0010, {BL, BL, 7'b1111001, Z}, {Z, Z, 7'b1111001, Z}};
        vecs[2] = '{16'h0589, {BL, 7'b0010010, 7'b0000000, 7'b0010000},
                              {Z, 7'b0010010, 7'b0000000, 7'b0010000}};
        vecs[3] = '{16'h00C4, {BL, BL, 7'b0111111, 7'b0011001},
                              {Z, Z, 7'b0111111, 7'b0011001}};
        vecs[4] = '{16'h0000, zero_bl, zero_nb};

        // Reset held for three cycles, then release.
        repeat (3) @(negedge clk);
        check_out("reset", 4'b1111, BL, BL, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_out("first_drive", 4'b1110, Z, Z, 1'b0);

        // Each vector: load early in a frame, that frame keeps the old value, next shows new.
        wait_fd();
        prev_bl = zero_bl;
        prev_nb = zero_nb;
        for (int i = 0; i < 5; i++) begin
            {thousands, hundreds, tens, ones} = vecs[i].digits;
            load = 1'b1;
            run_frame($sformatf("old_v%0d", i), prev_bl, prev_nb, 1'b0);
            run_frame($sformatf("new_v%0d", i), vecs[i].exp_bl, vecs[i].exp_nb, 1'b0);
            prev_bl = vecs[i].exp_bl;
            prev_nb = vecs[i].exp_nb;
        end

        // Boundary-cycle load is bypassed; the load one cycle later waits a frame.
        run_frame("bnd_pre", zero_bl, zero_nb, 1'b1);
        run_frame("bnd_1000", {7'b1111001, Z, Z, Z}, {7'b1111001, Z, Z, Z}, 1'b0);
        run_frame("bnd_0006", {BL, BL, BL, 7'b0000010}, {Z, Z, Z, 7'b0000010}, 1'b0);

        // Show a dash on tens, then reset in the middle of digit 2.
        {thousands, hundreds, tens, ones} = 16'h00C4;
        load = 1'b1;
        run_frame("pre_rst", {BL, BL, BL, 7'b0000010}, {Z, Z, Z, 7'b0000010}, 1'b0);
        repeat (10) begin
            @(negedge clk);
            load = 1'b0;
        end
        check_out("mid_digit2", 4'b1011, BL, Z, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_out("mid_reset", 4'b1111, BL, BL, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_out("restart", 4'b1110, Z, Z, 1'b0);
        wait_fd();
        run_frame("after_rst", zero_bl, zero_nb, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
